// File: rtl/enc_pkg.sv
// Shared widths and FSM state encoding for the encoder164 priority encoder.
// Optional serial multi-hot draining is enabled by ENC_MULTI_HOT_SERIAL_EN.
package enc_pkg;

  localparam int REQ_W  = 16;
  localparam int CODE_W = 4;

  typedef enum logic [0:0] {
    ENC_IDLE  = 1'b0,
    ENC_DRAIN = 1'b1
  } enc_state_e;

  // Mask with the bit at idx removed; used to step through a multi-hot word.
  function automatic logic [REQ_W-1:0] clear_bit(input logic [REQ_W-1:0] mask,
                                                 input logic [CODE_W-1:0] idx);
    return mask & ~(REQ_W'(1) << idx);
  endfunction

endpackage

// File: rtl/enc_prio16.sv
// Combinational 16-line priority encoder: highest set index wins.
// Also reports whether any line is set and whether more than one is set.
module enc_prio16
  import enc_pkg::*;
(
  input  logic [REQ_W-1:0]  mask,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              multi
);

  always_comb begin
    idx = '0;
    // Ascending scan so the last hit, the highest index, is kept.
    for (int i = 0; i < REQ_W; i++) begin
      if (mask[i]) idx = CODE_W'(i);
    end
    any   = |mask;
    multi = |(mask & (mask - REQ_W'(1)));
  end

endmodule

// File: rtl/encoder164.sv
// 16-to-4 registered priority encoder with valid/ready handshakes on both sides.
// Define ENC_MULTI_HOT_SERIAL_EN to emit one beat per set bit of a multi-hot word.
module encoder164
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] d,
  input  logic             e,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             w,
  output logic             gs,
  output logic             mh,
  output logic             last,
  output logic             out_valid,
  input  logic             out_ready
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // a producer holds its data stable while valid is high and ready is low.

  enc_state_e        state_q, state_d;
  logic [REQ_W-1:0]  mask_q, mask_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              gs_q, gs_d;
  logic              mh_q, mh_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              beat_done;
  logic [REQ_W-1:0]  residual;
  logic [REQ_W-1:0]  prio_in;
  logic [CODE_W-1:0] p_idx;
  logic              p_any;
  logic              p_multi;

  assign in_ready  = e & (~out_valid_q | (out_ready & last_q));
  assign accept    = in_valid & in_ready;
  assign beat_done = out_valid_q & out_ready;
  assign residual  = clear_bit(mask_q, code_q);
  // A new word always outranks the residual; both never need encoding together.
  assign prio_in   = accept ? d : residual;

  enc_prio16 u_prio (
    .mask  (prio_in),
    .idx   (p_idx),
    .any   (p_any),
    .multi (p_multi)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    code_d      = code_q;
    gs_d        = gs_q;
    mh_d        = mh_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      mask_d      = d;
      code_d      = p_idx;
      gs_d        = p_any;
      mh_d        = p_multi;
      out_valid_d = 1'b1;
`ifdef ENC_MULTI_HOT_SERIAL_EN
      last_d      = ~p_multi;
      state_d     = p_multi ? ENC_DRAIN : ENC_IDLE;
`else
      last_d      = 1'b1;
      state_d     = ENC_IDLE;
`endif
    end else if (beat_done) begin
      if (last_q) begin
        out_valid_d = 1'b0;
        mask_d      = '0;
        state_d     = ENC_IDLE;
      end else begin
`ifdef ENC_MULTI_HOT_SERIAL_EN
        mask_d = residual;
        code_d = p_idx;
        gs_d   = p_any;
        last_d = ~p_multi;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ENC_IDLE;
      mask_q      <= '0;
      code_q      <= '0;
      gs_q        <= 1'b0;
      mh_q        <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      code_q      <= code_d;
      gs_q        <= gs_d;
      mh_q        <= mh_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign {x, y, z, w} = code_q;
  assign gs        = gs_q;
  assign mh        = mh_q;
  assign last      = last_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/encoder164.md
ENCODER164 -- requirements
Module: encoder164

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: d  input  16  request lines, bit i = line i.
REQ-004 SHALL: e  input  1  enable; 0 blocks acceptance of new words.
REQ-005 SHALL: in_valid  input  1  d holds a word to encode.
REQ-006 SHALL: in_ready  output  1  block accepts d this cycle.
REQ-007 SHALL: x, y, z, w  output  1 each  registered code, x = MSB, w = LSB, matching the 4-to-16 decoder's select order.
REQ-008 SHALL: gs  output  1  group signal: at least one request bit set in the encoded beat.
REQ-009 SHALL: mh  output  1  the originating word had more than one bit set.
REQ-010 SHALL: last  output  1  final beat of the current word.
REQ-011 SHALL: out_valid  output  1  x/y/z/w/gs/mh/last are valid.
REQ-012 SHALL: out_ready  input  1  consumer accepts the current beat.

Function
REQ-013 SHALL: a word is accepted on a rising edge where in_valid & in_ready = 1.
REQ-014 SHALL: in_ready = e & (~out_valid | (out_ready & last)), combinational, with no dependency on in_valid.
REQ-015 SHALL: the output is registered with one-cycle latency: a word accepted at edge N drives out_valid = 1 after edge N.
REQ-016 SHALL: priority is highest index first; the code equals the index of the highest set bit of the residual mask.
REQ-017 SHALL: an all-zero word produces one beat with code 0, gs = 0, mh = 0, last = 1.
REQ-018 SHALL: while out_valid = 1 and out_ready = 0, all outputs hold stable.
REQ-019 SHALL: the FSM has two states. IDLE -> DRAIN when a multi-hot word is accepted with the macro set. DRAIN -> IDLE when the last beat is accepted.
REQ-020 SHALL: in DRAIN, each accepted beat clears the encoded bit from the residual mask and presents the next highest bit on the following cycle; last = 1 when exactly one residual bit remains.
REQ-021 SHALL: a new word is accepted in the same cycle as a last-beat handshake (back-to-back), giving no bubble.
REQ-022 SHALL: e deasserting mid-word does not stop draining of the pending residual; it only blocks new words.
REQ-023 SHALL: mh is computed once per word and holds for every beat of that word.

Reset
REQ-024 SHALL: while rst_n = 0: out_valid = 0, x = y = z = w = 0, gs = 0, mh = 0, last = 0, FSM = IDLE, residual mask = 0.
REQ-025 SHALL: reset asserted mid-drain discards the residual with no further beats.
REQ-026 SHALL: after reset release, in_ready = e.

Configuration
REQ-027 SHALL: macro ENC_MULTI_HOT_SERIAL_EN compiled in enables DRAIN, so a multi-hot word emits one beat per set bit, highest index first.
REQ-028 SHALL: without ENC_MULTI_HOT_SERIAL_EN, every word emits exactly one beat (highest set bit), last is tied to 1, DRAIN is unreachable, and mh still reports multi-hot.

Structure
REQ-029 SHALL: shared package enc_pkg holds REQ_W = 16, CODE_W = 4, and the FSM state enum (ENC_IDLE, ENC_DRAIN).
REQ-030 SHALL: sub-module enc_prio16 is combinational: 16-bit mask -> 4-bit index, any flag, multi flag. It is instantiated once.

Verification
REQ-031 SHALL: reset then d = 16'h0020, e = 1, in_valid = 1, out_ready = 1 -> next cycle xyzw = 0101, gs = 1, mh = 0, last = 1.
REQ-032 SHALL: macro set, d = 16'h8041 -> beats 1111, 0110, 0000 with mh = 1 on all three and last = 1 only on the third.
REQ-033 SHALL: macro unset, d = 16'h8041 -> single beat xyzw = 1111, mh = 1, last = 1.
REQ-034 SHALL: d = 0 -> one beat with gs = 0, xyzw = 0000, last = 1.
REQ-035 SHALL: out_ready low for 3 cycles after out_valid -> outputs stable, in_ready = 0; e = 0 with in_valid = 1 -> no acceptance.
REQ-036 SHALL: rst_n pulsed low during the second beat of 16'h0303 -> out_valid = 0 immediately, no residual beats after release, loop-back through the 4-to-16 decoder reproduces the highest set bit.
